pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 29 ++
 rtl/pc_target_calc.sv | 52 +++++
 rtl/pc_unit.sv | 130 +++++++++++++
 tb/tb_pc_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit: FSM states, redirect encodings, vectors.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pc_pkg;

    // Fetch sequencer states; pc_valid is asserted only while in ST_RUN.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    // Encodings carried on redirect_kind; RK_RSVD behaves as "no redirect".
    typedef enum logic [1:0] {
        RK_BRANCH = 2'd0,
        RK_JUMP   = 2'd1,
        RK_JREG   = 2'd2,
        RK_RSVD   = 2'd3
    } redirect_kind_t;

    // Default vectors, held 64 bits wide so any WIDTH in 8..64 can truncate them.
    localparam logic [63:0] PC_RESET_VECTOR = 64'h0000_0000_0000_0000;
    localparam logic [63:0] PC_EXC_VECTOR   = 64'h0000_0000_8000_0180;
    localparam int          PC_INC          = 4;

    // Jump targets replace the low 28 address bits (26-bit index shifted left by 2).
    localparam int          PC_JUMP_LOW_BITS = 28;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target generator: branch, jump and jump-register targets.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; target_vld is low for the reserved kind so the caller ignores it.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int INC   = PC_INC
) (
    input  logic [1:0]       redirect_kind,
    input  logic [WIDTH-1:0] redirect_base,
    input  logic [WIDTH-1:0] redirect_imm,
    output logic [WIDTH-1:0] target,
    output logic             target_vld
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    // Narrow builds (WIDTH < 28) keep only the bits that exist; the mask covers
    // the jump's replaced low field clipped to the address width.
    localparam int               LOW_BITS = (WIDTH < PC_JUMP_LOW_BITS) ? WIDTH : PC_JUMP_LOW_BITS;
    localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - LOW_BITS);

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] imm_word;
    logic [WIDTH-1:0] branch_tgt;
    logic [WIDTH-1:0] jump_tgt;
    logic [WIDTH-1:0] jreg_tgt;

    // Candidate targets; all sums wrap modulo 2^WIDTH by construction.
    always_comb begin
        seq_pc     = redirect_base + INC_W;
        imm_word   = redirect_imm << 2;
        branch_tgt = seq_pc + imm_word;
        // imm_word bits [27:2] are redirect_imm[25:0]; upper bits come from the delay-slot PC.
        jump_tgt   = (seq_pc & ~LOW_MASK) | (imm_word & LOW_MASK);
        jreg_tgt   = {redirect_imm[WIDTH-1:2], 2'b00};
    end

    // Select the target for the requested kind.
    always_comb begin
        target     = seq_pc;
        target_vld = 1'b1;
        unique case (redirect_kind)
            RK_BRANCH: target = branch_tgt;
            RK_JUMP:   target = jump_tgt;
            RK_JREG:   target = jreg_tgt;
            default:   target_vld = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALT sequencing, redirects and (PC_EPC_EN) exception entry/return.
// Latency: 1 cycle from inputs to registered pc/pc_valid/epc.
// Backpressure: stall holds pc with pc_valid high; halt drops pc_valid until resume. Macro: PC_EPC_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter logic [63:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [63:0] EXC_VECTOR   = PC_EXC_VECTOR,
    parameter int          INC          = PC_INC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             redirect_valid,
    input  logic [1:0]       redirect_kind,
    input  logic [WIDTH-1:0] redirect_base,
    input  logic [WIDTH-1:0] redirect_imm,
`ifdef PC_EPC_EN
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] epc,
`endif
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid
);

    localparam logic [WIDTH-1:0] RST_PC = RESET_VECTOR[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);

    pc_state_t        state;
    pc_state_t        state_nxt;
    logic [WIDTH-1:0] pc_nxt;
    logic             pc_valid_nxt;
    logic [WIDTH-1:0] target;
    logic             target_vld;

    pc_target_calc #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_target_calc (
        .redirect_kind (redirect_kind),
        .redirect_base (redirect_base),
        .redirect_imm  (redirect_imm),
        .target        (target),
        .target_vld    (target_vld)
    );

`ifdef PC_EPC_EN
    localparam logic [WIDTH-1:0] EXC_PC = EXC_VECTOR[WIDTH-1:0];
    logic [WIDTH-1:0] epc_nxt;
`endif

    // Next state and next PC. Inside RUN: exc > halt > eret > redirect > stall > increment.
    // Halt wins over flow changes so the PC that is parked is the one already fetched.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
`ifdef PC_EPC_EN
        epc_nxt   = epc;
`endif
        unique case (state)
            ST_BOOT: begin
                // First fetch is the reset vector itself, so pc is left untouched.
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_HALT;
`ifdef PC_EPC_EN
                end else if (eret) begin
                    pc_nxt = epc;
`endif
                end else if (redirect_valid && target_vld) begin
                    pc_nxt = target;
                end else if (!stall) begin
                    pc_nxt = pc + INC_W;
                end
            end
            ST_HALT: begin
                // Simultaneous halt and resume keeps the unit parked.
                if (resume && !halt) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
                pc_nxt    = RST_PC;
            end
        endcase
`ifdef PC_EPC_EN
        // Exception entry overrides everything outside BOOT and also wakes a halted unit.
        if (exc && (state == ST_RUN || state == ST_HALT)) begin
            state_nxt = ST_RUN;
            pc_nxt    = EXC_PC;
            epc_nxt   = pc;
        end
`endif
        pc_valid_nxt = (state_nxt == ST_RUN);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered fetch address, request flag and saved exception PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RST_PC;
            pc_valid <= 1'b0;
`ifdef PC_EPC_EN
            epc      <= '0;
`endif
        end else begin
            pc       <= pc_nxt;
            pc_valid <= pc_valid_nxt;
`ifdef PC_EPC_EN
            epc      <= epc_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic vs a behavioural model.
// Latency: expects registered outputs one cycle after each rising edge.
// Backpressure: exercises stall, halt/resume, async reset; exc/eret/epc only when PC_EPC_EN is defined.
module tb_pc_unit;

    localparam longint unsigned M32 = 64'hFFFF_FFFF;
`ifdef PC_EPC_EN
    localparam bit EPC_EN = 1'b1;
`else
    localparam bit EPC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        redirect_valid;
    logic [1:0]  redirect_kind;
    logic [31:0] redirect_base;
    logic [31:0] redirect_imm;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
    logic        pc_valid;
`ifdef PC_EPC_EN
    logic [31:0] epc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: mode 0 = booting, 1 = running, 2 = halted.
    int              m_mode;
    longint unsigned m_pc;
    longint unsigned m_epc;
    bit              m_valid;

    pc_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .halt           (halt),
        .resume         (resume),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .redirect_base  (redirect_base),
        .redirect_imm   (redirect_imm),
`ifdef PC_EPC_EN
        .exc            (exc),
        .eret           (eret),
        .epc            (epc),
`endif
        .pc             (pc),
        .pc_valid       (pc_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned model_target(input int kind, input longint unsigned base,
                                                     input longint unsigned imm);
        longint unsigned seq;
        seq = (base + 4) % 64'h1_0000_0000;
        if (kind == 0) return (base + 4 + imm * 4) % 64'h1_0000_0000;
        if (kind == 1) return (seq / 64'h1000_0000) * 64'h1000_0000 + (imm % 64'h400_0000) * 4;
        return imm - (imm % 4);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_epc   = 0;
        m_valid = 1'b0;
    endtask

    // Apply one rising edge's worth of the behavioural rules to the model.
    task automatic model_edge();
        if (reset_n) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (EPC_EN && exc) begin
                m_epc  = m_pc;
                m_pc   = 64'h8000_0180;
                m_mode = 1;
            end else if (m_mode == 2) begin
                if (resume && !halt) m_mode = 1;
            end else if (halt) begin
                m_mode = 2;
            end else if (EPC_EN && eret) begin
                m_pc = m_epc;
            end else if (redirect_valid && redirect_kind != 2'd3) begin
                m_pc = model_target(int'(redirect_kind), longint'(redirect_base), longint'(redirect_imm));
            end else if (!stall) begin
                m_pc = (m_pc + 4) & M32;
            end
            m_valid = (m_mode == 1);
        end
    endtask

    task automatic check_model();
        check("pc", {32'd0, pc}, m_pc);
        check("pc_valid", {63'd0, pc_valid}, {63'd0, m_valid});
`ifdef PC_EPC_EN
        check("epc", {32'd0, epc}, m_epc);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic clear_inputs();
        stall          = 1'b0;
        halt           = 1'b0;
        resume         = 1'b0;
        redirect_valid = 1'b0;
        redirect_kind  = 2'd0;
        redirect_base  = '0;
        redirect_imm   = '0;
        exc            = 1'b0;
        eret           = 1'b0;
    endtask

    task automatic jr_to(input logic [31:0] addr);
        clear_inputs();
        redirect_valid = 1'b1;
        redirect_kind  = 2'd2;
        redirect_imm   = addr;
        step();
        clear_inputs();
    endtask

    // Assert reset between edges; outputs must clear without any clock edge.
    task automatic do_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_pc", {32'd0, pc}, 64'd0);
        check("async_valid", {63'd0, pc_valid}, 64'd0);
`ifdef PC_EPC_EN
        check("async_epc", {32'd0, epc}, 64'd0);
`endif
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_pc", {32'd0, pc}, 64'd0);
        check("rst_valid", {63'd0, pc_valid}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("boot1_pc", {32'd0, pc}, 64'd0);
        check("boot1_valid", {63'd0, pc_valid}, 64'd0);
        step();
        check("boot2_pc", {32'd0, pc}, 64'd0);
        check("boot2_valid", {63'd0, pc_valid}, 64'd1);
        step();
        check("boot3_pc", {32'd0, pc}, 64'd4);

        // Branch with negative offset back onto itself; stall must be ignored.
        redirect_valid = 1'b1;
        redirect_kind  = 2'd0;
        redirect_base  = 32'h0000_0100;
        redirect_imm   = 32'hFFFF_FFFF;
        stall          = 1'b1;
        step();
        check("branch_pc", {32'd0, pc}, 64'h100);
        stall          = 1'b0;
        redirect_kind  = 2'd1;
        redirect_base  = 32'h1000_0000;
        redirect_imm   = 32'h0000_0040;
        step();
        check("jump_pc", {32'd0, pc}, 64'h1000_0100);
        redirect_kind  = 2'd2;
        redirect_imm   = 32'h0000_0203;
        step();
        check("jreg_pc", {32'd0, pc}, 64'h200);
        redirect_kind  = 2'd3;
        step();
        check("rsvd_pc", {32'd0, pc}, 64'h204);

        // Halt / resume, including halt+resume together and redirect ignored while halted.
        jr_to(32'h0000_0020);
        halt = 1'b1;
        step();
        check("halt_valid", {63'd0, pc_valid}, 64'd0);
        check("halt_pc", {32'd0, pc}, 64'h20);
        resume = 1'b1;
        step();
        check("halt_resume_valid", {63'd0, pc_valid}, 64'd0);
        clear_inputs();
        redirect_valid = 1'b1;
        redirect_kind  = 2'd2;
        redirect_imm   = 32'h500;
        step();
        check("halt_redirect_pc", {32'd0, pc}, 64'h20);
        clear_inputs();
        resume = 1'b1;
        step();
        check("resume_valid", {63'd0, pc_valid}, 64'd1);
        check("resume_pc", {32'd0, pc}, 64'h20);
        resume = 1'b0;
        step();
        check("resume_next_pc", {32'd0, pc}, 64'h24);

`ifdef PC_EPC_EN
        jr_to(32'h0000_0044);
        exc  = 1'b1;
        eret = 1'b1;
        step();
        check("exc_pc", {32'd0, pc}, 64'h8000_0180);
        check("exc_epc", {32'd0, epc}, 64'h44);
        clear_inputs();
        step();
        eret = 1'b1;
        step();
        check("eret_pc", {32'd0, pc}, 64'h44);
        clear_inputs();
`endif

        // Sequential wrap at the top of the address space.
        jr_to(32'hFFFF_FFFC);
        check("wrap_pre_pc", {32'd0, pc}, 64'hFFFF_FFFC);
        step();
        check("wrap_pc", {32'd0, pc}, 64'h0);

        // Async reset while halted, then a clean boot.
        jr_to(32'h0000_0080);
        halt = 1'b1;
        step();
        do_async_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check("post_rst_pc", {32'd0, pc}, 64'd0);
        check("post_rst_valid", {63'd0, pc_valid}, 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset_n        = 1'b1;
            halt           = ($urandom_range(0, 15) == 0);
            resume         = ($urandom_range(0, 3) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 3) == 0);
            redirect_kind  = 2'($urandom_range(0, 3));
            redirect_base  = $urandom;
            redirect_imm   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1023));
            exc            = EPC_EN && ($urandom_range(0, 31) == 0);
            eret           = EPC_EN && ($urandom_range(0, 15) == 0);
            step();
            if ($urandom_range(0, 99) == 0) do_async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
